// File: rtl/clk_gate_ctrl_pkg.sv
// clk_gate_ctrl_pkg: shared types and defaults for the clock-enable controller.
//   state_t          - controller state encoding (OFF, WAKE, ON, DRAIN)
//   IDLE_CYCLES_DEF  - default idle cycles spent in DRAIN before the clock stops
//   WAKE_CYCLES_DEF  - default cycles EN is high before ACK asserts
//   WAKE_COUNT_W     - width of the optional wake statistics counter
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int IDLE_CYCLES_DEF = 16;
  localparam int WAKE_CYCLES_DEF = 2;
  localparam int WAKE_COUNT_W    = 16;

endpackage

// File: rtl/clk_gate_ctrl_sat_counter.sv
// clk_gate_ctrl_sat_counter: W-bit up-counter that sticks at all-ones.
//   clk    - counting clock
//   rst_n  - asynchronous active-low reset, clears the count
//   inc    - increment request, sampled on the rising edge
//   count  - current count (registered)
module clk_gate_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: drives the EN pin of a downstream clock gate cell. The clock
// is turned on for requests or domain activity, reported stable via ACK after
// WAKE_CYCLES, and shut off after IDLE_CYCLES consecutive idle cycles.
// All outputs decode from the state register, so EN is glitch-free.
//   CLK        - free-running (ungated) source clock
//   RST_N      - asynchronous active-low reset
//   REQ        - explicit request for the gated clock
//   BUSY       - activity indication from the gated domain
//   FORCE_ON   - test/debug override holding the clock on
//   EN         - clock gate enable
//   ACK        - gated clock running and stable (level)
//   GATED      - clock currently off
//   WAKE_COUNT - saturating OFF->WAKE count; only with CLK_GATE_CTRL_STATS_EN
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ,
  input  logic BUSY,
  input  logic FORCE_ON,
  output logic EN,
  output logic ACK,
  output logic GATED
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  output logic [WAKE_COUNT_W-1:0] WAKE_COUNT
`endif
);

  localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("clk_gate_ctrl: IDLE_CYCLES must be >= 1");
  end
  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYCLES must be >= 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act;

  assign act = REQ | BUSY | FORCE_ON;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (act) begin
          state_d = WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      WAKE: begin
        // act is deliberately ignored: a started wake always completes.
        if (cnt_q == '0) begin
          state_d = ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ON: begin
        if (!act) begin
          state_d = DRAIN;
          cnt_d   = IDLE_LOAD;
        end
      end
      DRAIN: begin
        // The clock never stopped, so returning activity skips WAKE; it also
        // wins over an expiring idle count.
        if (act) begin
          state_d = ON;
        end else if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EN    = (state_q != OFF);
  assign ACK   = (state_q == ON);
  assign GATED = (state_q == OFF);

`ifdef CLK_GATE_CTRL_STATS_EN
  logic wake_inc;

  assign wake_inc = (state_q == OFF) && act;

  clk_gate_ctrl_sat_counter #(
    .W(WAKE_COUNT_W)
  ) u_wake_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (wake_inc),
    .count (WAKE_COUNT)
  );
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed and randomized checks of clk_gate_ctrl
// (IDLE_CYCLES=16, WAKE_CYCLES=2). The reference model tracks how many edges
// have elapsed since the clock was enabled and how many consecutive idle
// edges have been seen since it became stable.
module tb_clk_gate_ctrl;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic REQ = 1'b0;
  logic BUSY = 1'b0;
  logic FORCE_ON = 1'b0;
  logic EN, ACK, GATED;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0] WAKE_COUNT;
`endif

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .BUSY     (BUSY),
    .FORCE_ON (FORCE_ON),
    .EN       (EN),
    .ACK      (ACK),
    .GATED    (GATED)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .WAKE_COUNT (WAKE_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Reference model
  bit          m_en;
  int          m_up;    // edges elapsed since EN rose
  int          m_idle;  // consecutive idle edges once stable
  int unsigned m_wakes;

  task automatic model_reset();
    m_en = 0; m_up = 0; m_idle = 0; m_wakes = 0;
  endtask

  task automatic model_step(input bit act);
    if (!m_en) begin
      if (act) begin
        m_en = 1; m_up = 0; m_idle = 0;
        if (m_wakes < 32'hFFFF) m_wakes++;
      end
    end else if (m_up < WAKE) begin
      m_up++;
    end else begin
      if (act) m_idle = 0;
      else m_idle++;
      if (m_idle > IDLE) begin
        m_en = 0; m_up = 0; m_idle = 0;
      end
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic m_ack;
    m_ack = m_en && (m_up >= WAKE) && (m_idle == 0);
    check1({tag, ".EN"}, EN, m_en);
    check1({tag, ".ACK"}, ACK, m_ack);
    check1({tag, ".GATED"}, GATED, !m_en);
`ifdef CLK_GATE_CTRL_STATS_EN
    check_int({tag, ".WAKE_COUNT"}, int'(WAKE_COUNT), int'(m_wakes));
`endif
  endtask

  // Drive inputs, advance one edge, update the model, check #1 later.
  task automatic cycle(input bit req, input bit busy, input bit frc, input string tag);
    REQ = req; BUSY = busy; FORCE_ON = frc;
    @(posedge CLK);
    if (RST_N) model_step(req | busy | frc);
    #1;
    check_outs(tag);
  endtask

  initial begin
    int en_cnt;
    model_reset();

    // Reset held with REQ high
    RST_N = 1'b0; REQ = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_outs("rst_hold");
    check1("rst_hold_gated", GATED, 1'b1);
    RST_N = 1'b1;
    cycle(1, 0, 0, "rel_e1");
    check1("rel_en_e1", EN, 1'b1);
    cycle(1, 0, 0, "rel_e2");
    check1("rel_ack_e2", ACK, 1'b0);
    cycle(1, 0, 0, "rel_e3");
    check1("rel_ack_e3", ACK, 1'b1);

    // Idle shutdown: 16 DRAIN cycles after ACK drops
    cycle(0, 0, 0, "idle_e0");
    check1("idle_ack_drop", ACK, 1'b0);
    for (int i = 1; i < IDLE; i++) cycle(0, 0, 0, "idle");
    check1("idle_en_last", EN, 1'b1);
    cycle(0, 0, 0, "idle_e16");
    check1("idle_en_off", EN, 1'b0);
    check1("idle_gated", GATED, 1'b1);

    // Drain rescue at idle edge 10, then a full drain restarts
    cycle(1, 0, 0, "resc_wake");
    cycle(0, 0, 0, "resc_wake");
    cycle(0, 0, 0, "resc_on");
    check1("resc_on_ack", ACK, 1'b1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, "resc_drain");
    cycle(0, 1, 0, "resc_busy");
    check1("resc_ack_back", ACK, 1'b1);
    for (int i = 0; i < IDLE; i++) cycle(0, 0, 0, "resc_redrain");
    check1("resc_en_still", EN, 1'b1);
    cycle(0, 0, 0, "resc_off");
    check1("resc_en_off", EN, 1'b0);

    // Short request: count EN-high cycles, bounded
    cycle(1, 0, 0, "short_req");
    en_cnt = EN ? 1 : 0;
    for (int i = 0; i < 40 && EN; i++) begin
      cycle(0, 0, 0, "short_run");
      if (EN) en_cnt++;
    end
    check_int("short_en_cycles", en_cnt, 19);

    // FORCE_ON keeps the clock up regardless of REQ/BUSY
    cycle(0, 0, 1, "force_up");
    for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)), 0, 1, "force_hold");
    check1("force_ack", ACK, 1'b1);
    for (int i = 0; i <= IDLE; i++) cycle(0, 0, 0, "force_drain");
    check1("force_off", EN, 1'b0);

    // Async reset mid-WAKE, between edges
    cycle(1, 0, 0, "async_wake");
    check1("async_wake_en", EN, 1'b1);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_outs("async_rst");
    check1("async_en0", EN, 1'b0);
    cycle(1, 0, 0, "async_held");
    RST_N = 1'b1;

`ifdef CLK_GATE_CTRL_STATS_EN
    // Five full wake/drain sequences
    for (int w = 0; w < 5; w++) begin
      cycle(1, 0, 0, "stats_wake");
      for (int i = 0; i < WAKE + IDLE + 1; i++) cycle(0, 0, 0, "stats_drain");
    end
    check_int("stats_five", int'(WAKE_COUNT), 5);
`endif

    // Randomized phases of varying activity, with occasional async resets
    for (int seg = 0; seg < 24; seg++) begin
      int dens;
      dens = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 12 : 40);
      for (int i = 0; i < 40; i++) begin
        cycle(1'($urandom_range(0, dens - 1) == 0),
              1'($urandom_range(0, dens - 1) == 0),
              1'($urandom_range(0, 4 * dens) == 0), "rand");
      end
      if ($urandom_range(0, 5) == 0) begin
        #3;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_outs("rand_rst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
